piso_serializer: RTL and testbench



---
 rtl/piso_serializer_if.sv | 13 +
 rtl/piso_serializer.sv | 46 ++++
 tb/tb_piso_serializer.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/piso_serializer_if.sv
// piso_serializer_if: load handshake, inhibit and serial signals of the PISO serializer
interface piso_serializer_if #(parameter int WIDTH = 8);
    logic clk_inh, load_valid, load_ready, ser, ser_out, ser_valid, busy, done;
    logic [WIDTH-1:0] parallel_in, q;
    modport master (
        output clk_inh, load_valid, parallel_in, ser,
        input  load_ready, ser_out, ser_valid, busy, done, q
    );
    modport slave (
        input  clk_inh, load_valid, parallel_in, ser,
        output load_ready, ser_out, ser_valid, busy, done, q
    );
endinterface

// File: rtl/piso_serializer.sv
// piso_serializer: valid/ready loaded parallel-in serial-out shifter with gapless reload
module piso_serializer #(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b0,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input logic clk,
    input logic rst_n,
    piso_serializer_if.slave io
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t state, state_n;
    logic [WIDTH-1:0] sr, sr_n, shifted;
    logic [CW-1:0] cnt, cnt_n;
    logic step, last, load, done_q;
    // a reload on the last bit wins over the shift so the next word follows without a gap
    always_comb begin
        step = state == SHIFT && !io.clk_inh;
        last = step && cnt == '0;
        io.load_ready = state == IDLE || last;
        load = io.load_valid && io.load_ready;
        shifted = MSB_FIRST ? {sr[WIDTH-2:0], io.ser} : {io.ser, sr[WIDTH-1:1]};
        sr_n = load ? io.parallel_in : step ? shifted : sr;
        cnt_n = load ? CW'(WIDTH - 1) : step ? cnt - 1'b1 : cnt;
        state_n = load ? SHIFT : last ? IDLE : state;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            sr <= '0;
            cnt <= '0;
            done_q <= 1'b0;
        end else begin
            state <= state_n;
            sr <= sr_n;
            cnt <= cnt_n;
            done_q <= last;
        end
    end
    assign io.busy = state == SHIFT;
    assign io.ser_valid = state == SHIFT;
    assign io.ser_out = state == SHIFT ? (MSB_FIRST ? sr[WIDTH-1] : sr[0]) : IDLE_LEVEL;
    assign io.done = done_q;
    assign io.q = sr;
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: three serializer variants driven together, checked by table, sequences and a word-level model
module tb_piso_serializer;
    logic clk = 1'b0, rst_n = 1'b0, inh = 1'b0, lv = 1'b0, ser = 1'b0, chk = 1'b0;
    logic [15:0] din = '0;
    int n_checks = 0, n_fail = 0;
    always #5 clk = ~clk;

    piso_serializer_if #(.WIDTH(8))  i0();
    piso_serializer_if #(.WIDTH(8))  i1();
    piso_serializer_if #(.WIDTH(16)) i2();
    piso_serializer #(.WIDTH(8),  .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u0 (.clk(clk), .rst_n(rst_n), .io(i0));
    piso_serializer #(.WIDTH(8),  .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) u1 (.clk(clk), .rst_n(rst_n), .io(i1));
    piso_serializer #(.WIDTH(16), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u2 (.clk(clk), .rst_n(rst_n), .io(i2));

    assign i0.clk_inh = inh;  assign i0.load_valid = lv;  assign i0.parallel_in = din[7:0];  assign i0.ser = ser;
    assign i1.clk_inh = inh;  assign i1.load_valid = lv;  assign i1.parallel_in = din[7:0];  assign i1.ser = ~ser;
    assign i2.clk_inh = inh;  assign i2.load_valid = lv;  assign i2.parallel_in = din;       assign i2.ser = ser;

    logic [15:0] o_q [3];
    logic o_rdy [3], o_out [3], o_val [3], o_busy [3], o_done [3];
    assign o_q[0] = {8'h00, i0.q};  assign o_rdy[0] = i0.load_ready;  assign o_out[0] = i0.ser_out;
    assign o_val[0] = i0.ser_valid; assign o_busy[0] = i0.busy;       assign o_done[0] = i0.done;
    assign o_q[1] = {8'h00, i1.q};  assign o_rdy[1] = i1.load_ready;  assign o_out[1] = i1.ser_out;
    assign o_val[1] = i1.ser_valid; assign o_busy[1] = i1.busy;       assign o_done[1] = i1.done;
    assign o_q[2] = i2.q;           assign o_rdy[2] = i2.load_ready;  assign o_out[2] = i2.ser_out;
    assign o_val[2] = i2.ser_valid; assign o_busy[2] = i2.busy;       assign o_done[2] = i2.done;

    task automatic chk1(string name, logic act, logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkv(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // word-level reference: remaining bit count, bits emitted so far, original word, bits received on ser
    typedef struct packed {
        logic [5:0]  rem;
        logic [5:0]  k;
        logic [15:0] word;
        logic [15:0] rx;
        logic        done;
    } mstate_t;
    mstate_t m [3];

    function automatic int wd(int i); return i == 2 ? 16 : 8; endfunction
    function automatic logic msbf(int i); return i == 1; endfunction
    function automatic logic idle_lvl(int i); return i == 1; endfunction
    function automatic logic [15:0] mask(int w); return w == 16 ? 16'hFFFF : 16'h00FF; endfunction

    function automatic mstate_t mstep(mstate_t s, int w, logic r, logic ci, logic v, logic [15:0] d, logic sb);
        mstate_t n;
        logic rdy;
        n = s;
        rdy = s.rem == 0 || (s.rem == 1 && !ci);
        n.done = s.rem == 1 && !ci;
        if (v && rdy) begin
            n.word = d & mask(w);
            n.k = '0;
            n.rx = '0;
            n.rem = 6'(w);
        end else if (s.rem != 0 && !ci) begin
            n.rx[s.k[3:0]] = sb;
            n.k = s.k + 6'd1;
            n.rem = s.rem - 6'd1;
        end
        if (!r) n = '0;
        return n;
    endfunction

    function automatic logic mout(mstate_t s, int i);
        int k;
        k = int'(s.k);
        if (s.rem == 0) return idle_lvl(i);
        return s.word[msbf(i) ? wd(i) - 1 - k : k];
    endfunction

    function automatic logic [15:0] mq(mstate_t s, int i);
        logic [31:0] r;
        int k;
        k = int'(s.k);
        r = msbf(i) ? {16'h0, s.word} << k : {16'h0, s.word} >> k;
        for (int j = 0; j < k; j++) r[msbf(i) ? k - 1 - j : wd(i) - k + j] = s.rx[j];
        return r[15:0] & mask(wd(i));
    endfunction

    always @(posedge clk)
        for (int i = 0; i < 3; i++) m[i] <= mstep(m[i], wd(i), rst_n, inh, lv, din, i == 1 ? ~ser : ser);

    always @(negedge clk)
        if (chk)
            for (int i = 0; i < 3; i++) begin
                chk1($sformatf("model d%0d ready", i), o_rdy[i], m[i].rem == 0 || (m[i].rem == 1 && !inh));
                chk1($sformatf("model d%0d valid", i), o_val[i], m[i].rem != 0);
                chk1($sformatf("model d%0d busy", i), o_busy[i], m[i].rem != 0);
                chk1($sformatf("model d%0d ser_out", i), o_out[i], mout(m[i], i));
                chk1($sformatf("model d%0d done", i), o_done[i], m[i].done);
                chkv($sformatf("model d%0d q", i), 32'(o_q[i]), 32'(mq(m[i], i)));
            end

    typedef struct packed {
        logic        lv;
        logic [15:0] din;
        logic        sr, e_rdy, e_val, e_out0, e_out1, e_done;
    } vec_t;
    vec_t tbl [11];

    task automatic idle(int n);
        lv = 1'b0;
        inh = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    logic [31:0] bv, br, bd, bo, ir, id, ib, wb, wdn;
    logic took;

    initial begin
        // A5 emits 1,0,1,0,0,1,0,1 both LSB-first and MSB-first
        tbl = '{
            '{1'b1, 16'h00A5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0},
            '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0},
            '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0},
            '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0},
            '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0},
            '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0},
            '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0},
            '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0},
            '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0},
            '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1},
            '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}
        };
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk = 1'b1;

        repeat (5) begin
            @(negedge clk);
            chk1("rst ready", o_rdy[0], 1'b1);
            chk1("rst busy", o_busy[0], 1'b0);
            chk1("rst valid", o_val[0], 1'b0);
            chk1("rst ser_out", o_out[0], 1'b0);
            chk1("rst idle level d1", o_out[1], 1'b1);
            chk1("rst done", o_done[0], 1'b0);
            chkv("rst q", 32'(o_q[0]), 32'h0);
            @(posedge clk); #1;
        end

        for (int r = 0; r < 11; r++) begin
            lv = tbl[r].lv;
            din = tbl[r].din;
            ser = tbl[r].sr;
            @(negedge clk);
            chk1($sformatf("tbl[%0d] ready d0", r), o_rdy[0], tbl[r].e_rdy);
            chk1($sformatf("tbl[%0d] ready d1", r), o_rdy[1], tbl[r].e_rdy);
            chk1($sformatf("tbl[%0d] valid d0", r), o_val[0], tbl[r].e_val);
            chk1($sformatf("tbl[%0d] out d0", r), o_out[0], tbl[r].e_out0);
            chk1($sformatf("tbl[%0d] out d1", r), o_out[1], tbl[r].e_out1);
            chk1($sformatf("tbl[%0d] done d0", r), o_done[0], tbl[r].e_done);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chkv("lsb q after word", 32'(o_q[0]), 32'hFF);
        chkv("msb q after word", 32'(o_q[1]), 32'h00);

        idle(20);
        bv = '0; br = '0; bd = '0; bo = '0;
        lv = 1'b1; din = 16'h3C; ser = 1'b1; took = 1'b0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            bv[c] = o_val[0]; br[c] = o_rdy[0]; bd[c] = o_done[0];
            if (c >= 1 && c <= 16) bo[c-1] = o_out[0];
            if (lv && o_rdy[0] && din == 16'hC3) took = 1'b1;
            @(posedge clk); #1;
            if (took) lv = 1'b0; else din = 16'hC3;
        end
        chkv("b2b valid", bv, 32'h0001FFFE);
        chkv("b2b ready", br, 32'h01FF0101);
        chkv("b2b done", bd, 32'h00020200);
        chkv("b2b bits", bo, 32'hC33C);

        idle(20);
        ir = '0; id = '0; ib = '0; ser = 1'b1;
        for (int c = 0; c < 14; c++) begin
            lv = c <= 10;
            din = c == 0 ? 16'h5A : 16'h0;
            inh = c >= 5 && c <= 7;
            @(negedge clk);
            ir[c] = o_rdy[0]; id[c] = o_done[0];
            if (c >= 1 && c <= 5) ib[c-1] = o_out[0];
            if (c >= 9 && c <= 11) ib[c-4] = o_out[0];
            if (c >= 5 && c <= 8) begin
                chkv($sformatf("inh q c%0d", c), 32'(o_q[0]), 32'hF5);
                chk1($sformatf("inh out c%0d", c), o_out[0], 1'b1);
            end
            @(posedge clk); #1;
        end
        chkv("inh ready", ir, 32'h3801);
        chkv("inh done", id, 32'h1000);
        chkv("inh bits", ib, 32'h5A);

        idle(20);
        for (int c = 0; c < 10; c++) begin
            lv = c == 0;
            din = 16'hF0;
            rst_n = c != 5;
            @(negedge clk);
            if (c >= 6) begin
                chk1($sformatf("abort ready c%0d", c), o_rdy[0], 1'b1);
                chk1($sformatf("abort busy c%0d", c), o_busy[0], 1'b0);
                chk1($sformatf("abort done c%0d", c), o_done[0], 1'b0);
                chkv($sformatf("abort q c%0d", c), 32'(o_q[0]), 32'h0);
            end
            @(posedge clk); #1;
        end
        rst_n = 1'b1;

        idle(4);
        wb = '0; wdn = '0;
        lv = 1'b1; din = 16'hBEEF; ser = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            wdn[c] = o_done[2];
            if (c >= 1 && c <= 16) wb[c-1] = o_out[2];
            @(posedge clk); #1;
            lv = 1'b0;
        end
        chkv("w16 bits", wb, 32'hBEEF);
        chkv("w16 done", wdn, 32'h00020000);
        @(negedge clk);
        chkv("w16 q", 32'(o_q[2]), 32'hFFFF);
        @(posedge clk); #1;

        idle(20);
        for (int c = 0; c < 3000; c++) begin
            rst_n = $urandom_range(199) != 0;
            lv = 1'($urandom_range(1));
            din = 16'($urandom);
            ser = 1'($urandom);
            inh = $urandom_range(3) == 0;
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        lv = 1'b0;
        inh = 1'b0;
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
